pwm_deadtime: RTL and testbench

- Downstream stage of the single-ended PWM generator. It consumes that generator's 1-bit pwm_out and drives a complementary high-side/low-side gate pair.
- Inserts a programmable dead time, measured in clk_in cycles, at every transition so both switches are never on together (except dt==0, see Behaviour).
- Provides a latched fault shutdown with explicit clear. Sits between the PWM generator and the half-bridge driver pins.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_dt_timer.sv | 35 +++
 rtl/pwm_deadtime.sv | 104 ++++++++++
 tb/tb_pwm_deadtime.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output path: state encoding of the
// dead-time stage and the default dead-time counter width.
package pwm_pkg;

    localparam int DW_DEFAULT = 4;

    typedef enum logic [2:0] {
        LO    = 3'd0,
        DT_R  = 3'd1,
        HI    = 3'd2,
        DT_F  = 3'd3,
        FAULT = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/pwm_dt_timer.sv
// Dead-time down-counter: load on entry to a dead state, count down while
// enabled, done when the final cycle of the dead time is reached.
import pwm_pkg::*;

module pwm_dt_timer #(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk_in,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [DW-1:0] load_val_i,
    output logic          done_o
);

    localparam logic [DW-1:0] ONE = 1;

    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q > ONE)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        cnt_q <= cnt_d;
    end

    // A zero load counts as done so a dead state entered with dt==0 cannot stall.
    assign done_o = (cnt_q <= ONE);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate drive with programmable dead time and latched fault
// shutdown, fed by the single-ended PWM generator.
import pwm_pkg::*;

module pwm_deadtime #(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          pwm_in,
    input  logic [DW-1:0] dt,
    input  logic          fault_in,
    input  logic          clear_fault,
    output logic          pwm_hi,
    output logic          pwm_lo,
    output logic          in_dead,
    output logic          fault_latched,
    output logic [2:0]    dbg_state_o
);

    pwm_state_e state_q, state_d;
    logic       pwm_q;
    logic       tmr_load, tmr_en, tmr_done;

    pwm_dt_timer #(.DW(DW)) u_timer (
        .clk_in     (clk_in),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (dt),
        .done_o     (tmr_done)
    );

    // Priority: rst > fault_in > clear_fault > normal transitions.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        if (rst) begin
            state_d  = DT_F;
            tmr_load = 1'b1;
        end else if (fault_in) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                LO: if (pwm_q) begin
                    if (dt != '0) begin
                        state_d  = DT_R;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = HI;
                    end
                end
                DT_R: begin
                    if (!pwm_q)        state_d = LO;
                    else if (tmr_done) state_d = HI;
                    else               tmr_en  = 1'b1;
                end
                HI: if (!pwm_q) begin
                    if (dt != '0) begin
                        state_d  = DT_F;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = LO;
                    end
                end
                DT_F: begin
                    if (pwm_q)         state_d = HI;
                    else if (tmr_done) state_d = LO;
                    else               tmr_en  = 1'b1;
                end
                FAULT: if (clear_fault) begin
                    state_d  = DT_F;
                    tmr_load = 1'b1;
                end
                default: begin
                    state_d  = DT_F;
                    tmr_load = 1'b1;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pwm_q         <= 1'b0;
            state_q       <= DT_F;
            pwm_hi        <= 1'b0;
            pwm_lo        <= 1'b0;
            in_dead       <= 1'b1;
            fault_latched <= 1'b0;
        end else begin
            pwm_q         <= pwm_in;
            state_q       <= state_d;
            pwm_hi        <= (state_d == HI);
            pwm_lo        <= (state_d == LO);
            in_dead       <= (state_d == DT_R) || (state_d == DT_F);
            fault_latched <= (state_d == FAULT);
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: per-cycle expected output traces
// ({fault_latched, in_dead, hi, lo}) plus a hi/lo overlap watchdog.
module tb_pwm_deadtime;
    import pwm_pkg::*;

    localparam int DW = 4;

    localparam logic [3:0] O_LO = 4'b0001;
    localparam logic [3:0] O_HI = 4'b0010;
    localparam logic [3:0] O_DT = 4'b0100;
    localparam logic [3:0] O_FL = 4'b1000;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [DW-1:0] dt;
    logic          fault_in;
    logic          clear_fault;
    logic          pwm_hi, pwm_lo, in_dead, fault_latched;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    pwm_deadtime #(.DW(DW)) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .pwm_in        (pwm_in),
        .dt            (dt),
        .fault_in      (fault_in),
        .clear_fault   (clear_fault),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .in_dead       (in_dead),
        .fault_latched (fault_latched),
        .dbg_state_o   (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // One expected entry per clock edge; inputs changed after return apply at the next edge.
    task automatic drain(input string tag);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk_in);
            e = exp_q.pop_front();
            check(tag, {fault_latched, in_dead, pwm_hi, pwm_lo}, e);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst && dt != '0) check("no_overlap", pwm_hi & pwm_lo, 0);
    end

    initial begin
        rst = 1'b1; pwm_in = 1'b0; dt = 4'd3; fault_in = 1'b0; clear_fault = 1'b0;
        repeat (2) @(negedge clk_in);
        check("reset_outs", {fault_latched, in_dead, pwm_hi, pwm_lo}, O_DT);
        check("reset_state", dbg_state, DT_F);

        rst = 1'b0;
        push(O_DT, 2); push(O_LO, 2); drain("post_reset");

        // Rising edge, dt=3
        pwm_in = 1'b1;
        push(O_LO, 1); push(O_DT, 3); push(O_HI, 2); drain("rise_dt3");

        // Falling edge, dt=3
        pwm_in = 1'b0;
        push(O_HI, 1); push(O_DT, 3); push(O_LO, 2); drain("fall_dt3");

        // Glitch rejection, dt=5
        dt = 4'd5;
        pwm_in = 1'b1;
        push(O_LO, 1); push(O_DT, 1); drain("glitch_a");
        pwm_in = 1'b0;
        push(O_DT, 1); push(O_LO, 3); drain("glitch_b");

        // Zero dead time
        dt = 4'd0;
        pwm_in = 1'b1;
        push(O_LO, 1); push(O_HI, 2); drain("dt0_rise");
        pwm_in = 1'b0;
        push(O_HI, 1); push(O_LO, 2); drain("dt0_fall");

        // Fault and clear, dt=2
        dt = 4'd2;
        pwm_in = 1'b1;
        push(O_LO, 1); push(O_DT, 2); push(O_HI, 2); drain("flt_to_hi");
        fault_in = 1'b1;
        push(O_FL, 1); drain("flt_enter");
        clear_fault = 1'b1;
        push(O_FL, 1); drain("flt_clear_blocked");
        check("flt_state", dbg_state, FAULT);
        clear_fault = 1'b0; fault_in = 1'b0; pwm_in = 1'b0;
        push(O_FL, 1); drain("flt_hold");
        clear_fault = 1'b1;
        push(O_DT, 1); drain("flt_exit");
        check("flt_exit_state", dbg_state, DT_F);
        clear_fault = 1'b0;
        push(O_DT, 1); push(O_LO, 2); drain("flt_to_lo");

        // Reset mid-run, dt=4
        dt = 4'd4;
        pwm_in = 1'b1;
        push(O_LO, 1); push(O_DT, 4); push(O_HI, 2); drain("rst_to_hi");
        rst = 1'b1; pwm_in = 1'b0;
        push(O_DT, 1); drain("rst_mid");
        check("rst_mid_state", dbg_state, DT_F);
        rst = 1'b0;
        push(O_DT, 3); push(O_LO, 2); drain("rst_recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
